// File: rtl/nios_system_pio_pkg.sv
// rtl/nios_system_pio_pkg.sv - shared constants and edge helper for the input PIO
// Contents:
//   ADDR_*        register word addresses
//   edge_type_e   encodings for the EDGE_TYPE parameter
//   edge_detect   edge sensing for a given edge type (vectors up to 32 bits)
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Unknown encodings fall back to rising-edge sensing.
    function automatic logic [31:0] edge_detect(input int edge_type,
                                                input logic [31:0] cur,
                                                input logic [31:0] prv);
        if (edge_type == int'(EDGE_FALL)) begin
            return ~cur & prv;
        end else if (edge_type == int'(EDGE_ANY)) begin
            return cur ^ prv;
        end else begin
            return cur & ~prv;
        end
    endfunction

endpackage

// File: rtl/nios_system_pio_sync.sv
// rtl/nios_system_pio_sync.sv - WIDTH x STAGES flip-flop synchronizer
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, clears every stage
//   d        asynchronous input bus
//   q        synchronized output (last stage)
module nios_system_pio_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // stage[0] samples d; stage[STAGES-1] is the settled output.
    logic [STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in.sv
// rtl/nios_system_pio_in.sv - Avalon-MM input PIO with sticky edge capture and irq
// Optional feature macro: PIO_IN_IRQ_EN (IRQMASK register and irq logic; irq tied 0 when undefined)
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address           register word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata         write data, bits [WIDTH-1:0] used
//   in_port           external asynchronous inputs
//   readdata          registered read data, zero-extended
//   irq               registered level interrupt
module nios_system_pio_in
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Edges stay suppressed until the synchronizer and prev hold real
    // samples, so inputs already high at reset release are not captured.
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_MAX + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_MAX);

    logic [WIDTH-1:0]   sync_in;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   edge_capture;
    logic [WIDTH-1:0]   edge_hit;
    logic [WIDTH-1:0]   clr;
    logic [WIDTH-1:0]   mask_rd;
    logic [31:0]        edge_raw;
    logic [31:0]        rd_mux;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;
    logic               wr_en;

    nios_system_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_in)
    );

    assign wr_en    = chipselect & ~write_n;
    assign primed   = (prime_cnt == PRIME_DONE);
    assign edge_raw = edge_detect(EDGE_TYPE, 32'(sync_in), 32'(prev));
    assign edge_hit = primed ? edge_raw[WIDTH-1:0] : '0;
    assign clr      = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{writedata[31:WIDTH], edge_raw[31:WIDTH]};
        end
    endgenerate

    // Clear is applied before OR-ing in new edges so a same-cycle edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            prime_cnt    <= '0;
            edge_capture <= '0;
        end else begin
            prev <= sync_in;
            if (!primed) begin
                prime_cnt <= prime_cnt + PRIME_W'(1);
            end
            edge_capture <= (edge_capture & ~clr) | edge_hit;
        end
    end

`ifdef PIO_IN_IRQ_EN
    logic [WIDTH-1:0] irqmask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_capture & irqmask);
        end
    end

    assign mask_rd = irqmask;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    // Reads are unqualified: the mux is registered every clock.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = mask_rd;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios_system_pio_in.sv
// tb/tb_nios_system_pio_in.sv - self-checking bench for nios_system_pio_in
module tb_nios_system_pio_in;

    localparam int SS = 2;
    localparam int ET = 0;
`ifdef PIO_IN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'd0;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    nios_system_pio_in #(
        .WIDTH       (4),
        .SYNC_STAGES (SS),
        .EDGE_TYPE   (ET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: edge n (counted from reset release) sees in_port as
    // sampled SS-1 edges earlier; state is kept as register values per edge.
    logic [3:0]  in_hist [0:8191];
    int          cyc;
    logic [3:0]  m_cap, m_mask;
    logic [31:0] m_rd;
    logic        m_irq;

    function automatic logic [3:0] sync_at(int c);
        if (c - SS + 1 < 1) return 4'd0;
        return in_hist[c - SS + 1];
    endfunction

    function automatic logic [3:0] edges_of(logic [3:0] now_v, logic [3:0] before_v);
        if (ET == 1) return ~now_v & before_v;
        if (ET == 2) return now_v ^ before_v;
        return now_v & ~before_v;
    endfunction

    task automatic model_reset();
        cyc    = 0;
        m_cap  = 4'd0;
        m_mask = 4'd0;
        m_rd   = 32'd0;
        m_irq  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] iv, input logic [1:0] a,
                              input logic cs, input logic wr, input logic [31:0] wd);
        int c;
        logic [3:0] ed, clr;
        logic [31:0] rd;
        c = cyc + 1;
        in_hist[c] = iv;
        ed = (c >= SS + 2) ? edges_of(sync_at(c - 1), sync_at(c - 2)) : 4'd0;
        case (a)
            2'd0:    rd = {28'd0, sync_at(c - 1)};
            2'd2:    rd = {28'd0, m_mask};
            2'd3:    rd = {28'd0, m_cap};
            default: rd = 32'd0;
        endcase
        m_rd  = rd;
        m_irq = IRQ_ON ? |(m_cap & m_mask) : 1'b0;
        clr   = (cs && wr && a == 2'd3) ? wd[3:0] : 4'd0;
        m_cap = (m_cap & ~clr) | ed;
        if (IRQ_ON && cs && wr && a == 2'd2) m_mask = wd[3:0];
        cyc = c;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one clock, compare against the model.
    task automatic tick(input logic [3:0] iv, input logic [1:0] a,
                        input logic cs, input logic wr, input logic [31:0] wd);
        in_port    = iv;
        address    = a;
        chipselect = cs;
        write_n    = ~wr;
        writedata  = wd;
        model_step(iv, a, cs, wr, wd);
        @(posedge clk);
        #1;
        check("model readdata", readdata, m_rd);
        check("model irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset(input logic [3:0] hold_in);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset irq", {31'd0, irq}, 32'd0);
        check("async reset readdata", readdata, 32'd0);
        model_reset();
        in_port = hold_in;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  in_v;
        logic [1:0]  addr;
        logic        cs;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        rd_is_mask;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [3:0] iv, logic [1:0] a, logic cs, logic wr,
                                logic [31:0] wd, logic [31:0] rd, logic mk, logic ir);
        vec_t v;
        v.in_v = iv; v.addr = a; v.cs = cs; v.wr = wr; v.wd = wd;
        v.rd = rd; v.rd_is_mask = mk; v.irq = ir;
        tbl.push_back(v);
    endfunction

    initial begin
        // Row k is consumed by edge k+1 after reset release; rd/irq are the
        // values seen just after that edge.
        for (int i = 0; i < 6; i++) add(4'hF, 2'd3, 1, 0, 0, 32'h0, 0, 0);  // priming
        add(4'hA, 2'd0, 1, 0, 0, 32'hF, 0, 0);
        add(4'hA, 2'd0, 1, 0, 0, 32'hF, 0, 0);
        add(4'hA, 2'd0, 1, 0, 0, 32'hA, 0, 0);   // DATA 3 clocks after change
        add(4'h0, 2'd0, 1, 0, 0, 32'hA, 0, 0);
        add(4'h0, 2'd0, 1, 0, 0, 32'hA, 0, 0);
        add(4'h0, 2'd0, 1, 0, 0, 32'h0, 0, 0);
        add(4'h2, 2'd3, 1, 0, 0, 32'h0, 0, 0);   // pulse bit 1 for 2 clocks
        add(4'h2, 2'd3, 1, 0, 0, 32'h0, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h0, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h2, 0, 0);   // sticky
        add(4'h0, 2'd3, 1, 0, 0, 32'h2, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h2, 0, 0);
        add(4'h0, 2'd2, 1, 1, 32'h2, 32'h0, 1, 0); // IRQMASK=2
        add(4'h0, 2'd2, 1, 0, 0, 32'h2, 1, 1);   // irq rises
        add(4'h0, 2'd3, 1, 1, 32'h2, 32'h2, 0, 1); // W1C bit 1
        add(4'h0, 2'd3, 1, 0, 0, 32'h0, 0, 0);   // irq falls
        add(4'h0, 2'd2, 1, 1, 32'h1, 32'h2, 1, 0); // IRQMASK=1
        add(4'h1, 2'd3, 1, 0, 0, 32'h0, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h0, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h0, 0, 0);
        add(4'h0, 2'd3, 1, 0, 0, 32'h1, 0, 1);
        add(4'h1, 2'd3, 1, 0, 0, 32'h1, 0, 1);
        add(4'h1, 2'd3, 1, 0, 0, 32'h1, 0, 1);
        add(4'h1, 2'd3, 1, 1, 32'h1, 32'h1, 0, 1); // clear collides with new edge
        add(4'h1, 2'd3, 1, 0, 0, 32'h1, 0, 1);   // set wins
        add(4'h1, 2'd3, 1, 0, 0, 32'h1, 0, 1);
        add(4'h1, 2'd1, 1, 1, 32'hFFFFFFFF, 32'h0, 0, 1); // reserved write ignored
        add(4'h1, 2'd0, 1, 1, 32'hF, 32'h1, 0, 1);        // DATA write ignored
        add(4'h1, 2'd2, 1, 0, 0, 32'h1, 1, 1);
        add(4'h1, 2'd3, 0, 1, 32'h1, 32'h1, 0, 1); // write without chipselect
        add(4'h1, 2'd3, 0, 0, 0, 32'h1, 0, 1);     // unqualified read

        model_reset();
        in_port = 4'hF;
        address = 2'd3;
        chipselect = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset readdata", readdata, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            logic [31:0] erd;
            tick(tbl[i].in_v, tbl[i].addr, tbl[i].cs, tbl[i].wr, tbl[i].wd);
            erd = (tbl[i].rd_is_mask && !IRQ_ON) ? 32'd0 : tbl[i].rd;
            check($sformatf("vec%0d readdata", i), readdata, erd);
            check($sformatf("vec%0d irq", i), {31'd0, irq},
                  {31'd0, IRQ_ON ? tbl[i].irq : 1'b0});
        end

        // Mid-operation reset with irq pending and in_port held high.
        async_reset(4'h1);
        tick(4'h1, 2'd2, 1, 0, 0);
        tick(4'h1, 2'd2, 1, 0, 0);
        check("post-reset IRQMASK", readdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(4'h1, 2'd3, 1, 0, 0);
            check($sformatf("post-reset EDGECAP%0d", i), readdata, 32'd0);
            check($sformatf("post-reset irq%0d", i), {31'd0, irq}, 32'd0);
        end

        // Randomised traffic against the model, with one reset in the middle.
        begin
            logic [3:0] iv;
            iv = 4'h1;
            for (int i = 0; i < 1600; i++) begin
                logic [1:0]  a;
                logic        cs, wr;
                logic [31:0] wd;
                if (i == 800) async_reset(iv);
                if ($urandom_range(0, 2) == 0) iv = 4'($urandom);
                a  = 2'($urandom);
                cs = ($urandom_range(0, 3) != 0);
                wr = ($urandom_range(0, 3) == 0);
                wd = $urandom;
                tick(iv, a, cs, wr, wd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
